// File: rtl/pmod_share_arbiter.sv
// Round-robin time-sharing of the 16-bit PMOD GPIO bank among N_REQ requesters, with a
// break-before-make guard between owners, a hold timeout and an APB register file.
module pmod_share_arbiter #(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_int,
  input  logic [31:0]           PADDR,
  input  logic                  PENABLE,
  input  logic                  PSEL,
  input  logic [31:0]           PWDATA,
  input  logic                  PWRITE,
  input  logic [3:0]            PSTRB,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  irq,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      gnt,
  input  logic [16*N_REQ-1:0]   req_gpo,
  input  logic [16*N_REQ-1:0]   req_gpio_oe,
  output logic [15:0]           req_gpi,
  input  logic [15:0]           pmod_gpi,
  output logic [15:0]           pmod_gpo,
  output logic [15:0]           pmod_gpio_oe
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGuard = 2'd1;
  localparam logic [1:0] StOwned = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       guard_q, guard_d;
  logic [15:0]      hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [15:0]      gpo_q, gpo_d;
  logic [15:0]      oe_q, oe_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [15:0]      timeout_q, timeout_d;
  logic             flag_q, flag_d;
  logic             irq_q, irq_d;

  logic             apb_wr;
  logic [1:0]       apb_off;
  logic             en, irq_en, lock;
  logic [N_REQ-1:0] owner_oh;
  logic             owner_req;
  logic [15:0]      owner_gpo, owner_oe;
  logic             rr_found, nx_found, to_evt;
  logic [1:0]       rr_idx, nx_idx;
  logic             unused_bits;

  assign apb_wr  = PSEL & PENABLE & PWRITE;
  assign apb_off = PADDR[3:2];
  assign en      = ctrl_q[0];
  assign irq_en  = ctrl_q[1];
  assign lock    = ctrl_q[2];
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16], PSTRB[3:2]};

  always_comb begin
    owner_oh  = '0;
    owner_gpo = '0;
    owner_oe  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (owner_q == 2'(i)) begin
        owner_oh[i] = 1'b1;
        owner_gpo   = req_gpo[16*i +: 16];
        owner_oe    = req_gpio_oe[16*i +: 16];
      end
    end
  end
  assign owner_req = |(req & owner_oh);

  // rr_*: first requester after last_owner (last_owner itself comes last).
  // nx_*: first other requester after the current owner, used on a timeout revoke.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    nx_found = 1'b0;
    nx_idx   = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!rr_found && req[i] && (i == (int'(last_q) + k) % int'(N_REQ))) begin
          rr_found = 1'b1;
          rr_idx   = 2'(i);
        end
        if (k < int'(N_REQ) && !nx_found && req[i] &&
            (i == (int'(owner_q) + k) % int'(N_REQ))) begin
          nx_found = 1'b1;
          nx_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    guard_d = guard_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    gpo_d   = '0;
    oe_d    = '0;
    to_evt  = 1'b0;
    if (!en) begin
      state_d = StIdle;
      gnt_d   = '0;
      guard_d = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          gnt_d = '0;
          if (!lock && rr_found) begin
            state_d = StGuard;
            owner_d = rr_idx;
            guard_d = 8'(GUARD_CYCLES - 1);
          end
        end
        StGuard: begin
          gnt_d = '0;
          if (lock) begin
            state_d = StIdle;
            guard_d = '0;
          end else if (guard_q == '0) begin
            if (owner_req) begin
              state_d = StOwned;
              gnt_d   = owner_oh;
              last_d  = owner_q;
              hold_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            guard_d = guard_q - 8'd1;
          end
        end
        StOwned: begin
          // Release takes priority over a timeout in the same cycle.
          if (!owner_req) begin
            state_d = StIdle;
            gnt_d   = '0;
            hold_d  = '0;
          end else if (timeout_q != '0 && !lock && hold_q >= timeout_q - 16'd1 && nx_found) begin
            to_evt  = 1'b1;
            state_d = StGuard;
            owner_d = nx_idx;
            guard_d = 8'(GUARD_CYCLES - 1);
            gnt_d   = '0;
            hold_d  = '0;
          end else begin
            hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
            gpo_d  = owner_gpo;
            oe_d   = owner_oe;
          end
        end
        default: begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    timeout_d = timeout_q;
    flag_d    = flag_q;
    if (apb_wr && apb_off == 2'd0 && PSTRB[0]) ctrl_d = PWDATA[2:0];
    if (apb_wr && apb_off == 2'd1) begin
      if (PSTRB[0]) timeout_d[7:0]  = PWDATA[7:0];
      if (PSTRB[1]) timeout_d[15:8] = PWDATA[15:8];
    end
    if (apb_wr && apb_off == 2'd2 && PSTRB[1] && PWDATA[8]) flag_d = 1'b0;
    if (to_evt) flag_d = 1'b1;
    irq_d = flag_q & irq_en;
  end

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      last_q    <= 2'(N_REQ - 1);
      guard_q   <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gpo_q     <= '0;
      oe_q      <= '0;
      ctrl_q    <= '0;
      timeout_q <= '0;
      flag_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      guard_q   <= guard_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gpo_q     <= gpo_d;
      oe_q      <= oe_d;
      ctrl_q    <= ctrl_d;
      timeout_q <= timeout_d;
      flag_q    <= flag_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (apb_off)
        2'd0: PRDATA[2:0]  = ctrl_q;
        2'd1: PRDATA[15:0] = timeout_q;
        2'd2: begin
          PRDATA[0]   = (state_q == StOwned);
          PRDATA[2:1] = owner_q;
          PRDATA[3]   = (state_q == StGuard);
          PRDATA[8]   = flag_q;
        end
        default: PRDATA = '0;
      endcase
    end
  end

  assign PREADY       = 1'b1;
  assign PSLVERR      = PSEL & PENABLE & (apb_off == 2'd3);
  assign irq          = irq_q;
  assign gnt          = gnt_q;
  assign pmod_gpo     = gpo_q;
  assign pmod_gpio_oe = oe_q;
  assign req_gpi      = pmod_gpi;

endmodule

// File: tb/tb_pmod_share_arbiter.sv
// Bench for pmod_share_arbiter: a timestamp-based reference model feeds a scoreboard queue that
// a negedge monitor drains, plus directed latency and register scenarios and random traffic.
module tb_pmod_share_arbiter;

  localparam int N = 2;
  localparam int G = 4;

  logic            clk_in = 1'b0;
  logic            reset_int;
  logic [31:0]     PADDR, PWDATA, PRDATA;
  logic            PENABLE, PSEL, PWRITE, PREADY, PSLVERR, irq;
  logic [3:0]      PSTRB;
  logic [N-1:0]    req, gnt;
  logic [16*N-1:0] req_gpo, req_gpio_oe;
  logic [15:0]     req_gpi, pmod_gpi, pmod_gpo, pmod_gpio_oe;

  pmod_share_arbiter #(.N_REQ(N), .GUARD_CYCLES(G)) dut (
    .clk_in(clk_in), .reset_int(reset_int), .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL),
    .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq(irq), .req(req), .gnt(gnt), .req_gpo(req_gpo),
    .req_gpio_oe(req_gpio_oe), .req_gpi(req_gpi), .pmod_gpi(pmod_gpi), .pmod_gpo(pmod_gpo),
    .pmod_gpio_oe(pmod_gpio_oe)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic         known;
    logic [N-1:0] gnt;
    logic [15:0]  gpo;
    logic [15:0]  oe;
    logic         irq;
  } snap_t;

  snap_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = nobody, 1 = switchover gap, 2 = someone holds the bank.
  int           cyc = 0;
  int           m_mode = 0, m_owner = 0, m_last = N - 1, m_grant_at = 0, m_own_start = 0;
  logic         m_known = 1'b0;
  logic [2:0]   m_ctrl = '0;
  logic [15:0]  m_to = '0, m_gpo = '0, m_oe = '0;
  logic         m_flag = 1'b0, m_irq = 1'b0;
  logic [N-1:0] m_gnt = '0;

  function automatic int rr_pick(input logic [N-1:0] r, input int base, input int span);
    for (int k = 1; k <= span; k++) begin
      int c;
      c = (base + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic wr;
    logic [1:0] off;
    logic to_evt;
    int cand;
    wr = PSEL & PENABLE & PWRITE;
    off = PADDR[3:2];
    to_evt = 1'b0;
    cyc++;
    if (reset_int) begin
      m_known = 1'b1; m_mode = 0; m_owner = 0; m_last = N - 1; m_ctrl = '0; m_to = '0;
      m_flag = 1'b0; m_irq = 1'b0; m_gnt = '0; m_gpo = '0; m_oe = '0;
    end else begin
      m_irq = m_flag & m_ctrl[1];
      m_gpo = '0;
      m_oe  = '0;
      if (!m_ctrl[0]) begin
        m_mode = 0;
        m_gnt  = '0;
      end else if (m_mode == 0) begin
        cand = rr_pick(req, m_last, N);
        if (!m_ctrl[2] && cand >= 0) begin
          m_mode = 1; m_owner = cand; m_grant_at = cyc + G;
        end
      end else if (m_mode == 1) begin
        if (m_ctrl[2]) m_mode = 0;
        else if (cyc == m_grant_at) begin
          if (req[m_owner]) begin
            m_mode = 2; m_gnt = '0; m_gnt[m_owner] = 1'b1; m_last = m_owner; m_own_start = cyc;
          end else m_mode = 0;
        end
      end else begin
        cand = rr_pick(req, m_owner, N - 1);
        if (!req[m_owner]) begin
          m_mode = 0; m_gnt = '0;
        end else if (m_to != '0 && !m_ctrl[2] && (cyc - m_own_start) >= int'(m_to) &&
                     cand >= 0) begin
          to_evt = 1'b1; m_gnt = '0; m_mode = 1; m_owner = cand; m_grant_at = cyc + G;
        end else begin
          m_gpo = req_gpo[16*m_owner +: 16];
          m_oe  = req_gpio_oe[16*m_owner +: 16];
        end
      end
      if (wr && off == 2'd2 && PSTRB[1] && PWDATA[8]) m_flag = 1'b0;
      if (to_evt) m_flag = 1'b1;
      if (wr && off == 2'd0 && PSTRB[0]) m_ctrl = PWDATA[2:0];
      if (wr && off == 2'd1 && PSTRB[0]) m_to[7:0] = PWDATA[7:0];
      if (wr && off == 2'd1 && PSTRB[1]) m_to[15:8] = PWDATA[15:8];
    end
    exp_q.push_back('{m_known, m_gnt, m_gpo, m_oe, m_irq});
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] off);
    logic [31:0] v;
    v = '0;
    if (off == 2'd0) v[2:0] = m_ctrl;
    if (off == 2'd1) v[15:0] = m_to;
    if (off == 2'd2) begin
      v[0] = (m_mode == 2); v[2:1] = 2'(m_owner); v[3] = (m_mode == 1); v[8] = m_flag;
    end
    return v;
  endfunction

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  // Monitor: owner index in STATUS is only meaningful while the bank is owned.
  initial begin : monitor
    snap_t s;
    logic [31:0] want, mask;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        if (s.known) begin
          n_tests++;
          if ({gnt, pmod_gpo, pmod_gpio_oe, irq} !== {s.gnt, s.gpo, s.oe, s.irq}) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d got gnt=%b gpo=%h oe=%h irq=%b want gnt=%b gpo=%h oe=%h irq=%b",
                     cyc, gnt, pmod_gpo, pmod_gpio_oe, irq, s.gnt, s.gpo, s.oe, s.irq);
          end
          n_tests++;
          if (req_gpi !== pmod_gpi) begin
            n_fail++;
            $display("FAIL req_gpi cyc=%0d got %h want %h", cyc, req_gpi, pmod_gpi);
          end
          if (PSEL && PENABLE) begin
            n_tests++;
            if (PSLVERR !== (PADDR[3:2] == 2'd3)) begin
              n_fail++;
              $display("FAIL pslverr cyc=%0d got %b off=%0d", cyc, PSLVERR, PADDR[3:2]);
            end
          end
          if (PSEL && PENABLE && !PWRITE) begin
            want = exp_rd(PADDR[3:2]);
            mask = (PADDR[3:2] == 2'd2 && !want[0]) ? 32'hFFFF_FFF9 : 32'hFFFF_FFFF;
            n_tests++;
            if ((PRDATA & mask) !== (want & mask)) begin
              n_fail++;
              $display("FAIL prdata cyc=%0d off=%0d got %h want %h", cyc, PADDR[3:2], PRDATA, want);
            end
          end else if (!PSEL) begin
            n_tests++;
            if (PRDATA !== 32'h0) begin
              n_fail++;
              $display("FAIL prdata_idle cyc=%0d got %h want 0", cyc, PRDATA);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
    step(1);
    PENABLE = 1'b1;
    step(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    step(1);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    err = PSLVERR;
    step(1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    reset_int = 1'b1;
    req = '0;
    step(2);
    reset_int = 1'b0;
  endtask

  // Cycles from now until gnt[idx] is seen high, bounded by budget.
  task automatic wait_gnt(input int idx, input int budget, output int cnt, output logic oe_seen);
    cnt = 0;
    oe_seen = 1'b0;
    while (!gnt[idx] && cnt < budget) begin
      step(1);
      cnt++;
      oe_seen |= (pmod_gpio_oe != '0);
    end
  endtask

  initial begin : stim
    int cnt;
    logic oe_seen, err;
    logic [31:0] d;
    PADDR = '0; PWDATA = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
    req_gpo = '0; req_gpio_oe = '0; pmod_gpi = '0;
    do_reset();
    check("reset_gnt", int'(gnt), 0);
    check("reset_gpo", int'(pmod_gpo), 0);
    check("reset_oe", int'(pmod_gpio_oe), 0);
    check("reset_irq", int'(irq), 0);

    // Single requester: grant latency and one-cycle data latency.
    apb_wr(32'h0, 32'h1, 4'hF);
    req_gpo[15:0] = 16'hA5A5; req_gpio_oe[15:0] = 16'hFFFF; req[0] = 1'b1;
    wait_gnt(0, 50, cnt, oe_seen);
    check("grant_latency", cnt, G + 1);
    check("oe_low_in_guard", int'(oe_seen), 0);
    step(1);
    check("gpo_follows", int'(pmod_gpo), 16'hA5A5);

    // Simultaneous requests: round-robin from last_owner = N-1, then handover on release.
    do_reset();
    apb_wr(32'h0, 32'h1, 4'hF);
    req = 2'b11;
    wait_gnt(0, 50, cnt, oe_seen);
    check("rr_first", int'(gnt), 1);
    step(3);
    req[0] = 1'b0;
    wait_gnt(1, 50, cnt, oe_seen);
    check("handover_latency", cnt, G + 2);
    check("handover_oe_gap", int'(oe_seen), 0);

    // Timeout revoke.
    do_reset();
    apb_wr(32'h4, 32'd20, 4'hF);
    apb_wr(32'h0, 32'h3, 4'hF);
    req = 2'b01;
    wait_gnt(0, 50, cnt, oe_seen);
    req[1] = 1'b1;
    cnt = 1;
    while (gnt[0] && cnt < 100) begin
      step(1);
      if (gnt[0]) cnt++;
    end
    check("timeout_hold", cnt, 20);
    cnt = 1;
    while (!gnt[1] && cnt < 50) begin
      step(1);
      cnt++;
    end
    check("revoke_to_grant", cnt, G + 1);
    check("irq_set", int'(irq), 1);
    apb_rd(32'h8, d, err);
    check("status_flag_set", int'(d[8]), 1);
    apb_wr(32'h8, 32'h100, 4'hF);
    step(1);
    check("irq_cleared", int'(irq), 0);
    req = '0;
    step(3);

    // Lock keeps the owner past the timeout.
    do_reset();
    apb_wr(32'h4, 32'd20, 4'hF);
    apb_wr(32'h0, 32'h3, 4'hF);
    req = 2'b01;
    wait_gnt(0, 50, cnt, oe_seen);
    apb_wr(32'h0, 32'h7, 4'hF);
    req[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (gnt[0]) cnt++;
    end
    check("lock_hold", cnt, 200);
    apb_rd(32'h8, d, err);
    check("lock_no_flag", int'(d[8]), 0);

    // Clearing en while owned, then reset during the guard interval.
    apb_wr(32'h0, 32'h0, 4'hF);
    step(1);
    check("en_clear_gnt", int'(gnt), 0);
    check("en_clear_oe", int'(pmod_gpio_oe), 0);
    apb_wr(32'h0, 32'h1, 4'hF);
    step(2);
    reset_int = 1'b1;
    step(1);
    reset_int = 1'b0;
    check("reset_mid_gnt", int'(gnt), 0);
    check("reset_mid_out", int'({pmod_gpo, pmod_gpio_oe}), 0);
    apb_rd(32'h8, d, err);
    check("reset_mid_status", int'(d[3:0]), 0);

    // Register corner cases.
    apb_rd(32'hC, d, err);
    check("off_c_slverr", int'(err), 1);
    check("off_c_rdata", int'(d), 0);
    apb_wr(32'h0, 32'h1, 4'hF);
    apb_wr(32'h0, 32'h7, 4'h0);
    apb_rd(32'h0, d, err);
    check("pstrb_zero", int'(d), 1);
    pmod_gpi = 16'h1234;
    #1;
    check("gpi_bcast", int'(req_gpi), 16'h1234);

    // Random traffic against the reference model.
    req = '0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
        req_gpo[16*i +: 16] = 16'($urandom);
        req_gpio_oe[16*i +: 16] = 16'($urandom);
      end
      pmod_gpi = 16'($urandom);
      case ($urandom_range(0, 59))
        0: apb_wr(32'h0, {29'b0, ($urandom_range(0, 7) == 0), 1'($urandom),
                          ($urandom_range(0, 7) != 0)}, 4'($urandom));
        1: apb_wr(32'h4, 32'($urandom_range(0, 40)), 4'($urandom));
        2: apb_wr(32'h8, 32'h100, 4'hF);
        3: apb_rd({28'b0, 2'($urandom), 2'b00}, d, err);
        default: step(1);
      endcase
    end
    step(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
